twos_to_signmag_serial: RTL
===========================

Name: twos_to_signmag_serial

Overview:
- Bit-serial converter from WIDTH-bit two's complement to sign-magnitude form.
- Decode-side counterpart of the combinational negator. A word is accepted over a valid/ready handshake, the magnitude is built LSB-first with the "copy through first 1, then invert" rule, and the result is presented over a second valid/ready handshake.
- Sits between the ALU result path and display/sign-magnitude consumers, where area matters more than throughput.

Parameters:
- WIDTH, 8, data width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  two's complement operand.
- out_valid  output  1  out_sign/out_mag hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  1 = negative operand.
- out_mag  output  WIDTH  unsigned magnitude |in_data|.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: on a rising edge with rst=1, the block goes to IDLE and clears all registers.
  - out_valid=0, out_sign=0, out_mag=0, busy=0, bit counter=0, found_one=0.
  - in_ready=1 from the first cycle after the reset edge.
  - rst has priority over every other input.
- IDLE (in_ready=1, out_valid=0):
  - On in_valid=1 at an edge: load in_data into the shift register, latch sign=in_data[WIDTH-1], clear found_one and the counter, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT (in_ready=0, busy=1): one bit per cycle for exactly WIDTH cycles. With b = shift_reg[0]:
  - sign=0: result bit = b.
  - sign=1: result bit = found_one ? ~b : b; then found_one <= found_one | b.
  - The result bit shifts in at the MSB of the result register (right shift), and the operand register shifts right.
  - The counter increments each cycle. On the edge that processes bit WIDTH-1, go to DONE and set out_valid=1.
  - in_valid is ignored in SHIFT.
- DONE (out_valid=1, in_ready=0, busy=1):
  - out_sign = latched sign; out_mag = result register.
  - Both stay stable until the edge where out_ready=1.
  - On that edge: out_valid <= 0, go to IDLE.
  - out_mag and out_sign hold their last value after the handshake; they are don't-care while out_valid=0.
- Latency: the accept edge is E0. out_valid is high in the cycle following edge E0+WIDTH.
  - Minimum accept-to-accept spacing is WIDTH+2 cycles (one DONE cycle with out_ready=1, plus one IDLE cycle).
  - No overlap between words: in_ready stays 0 until IDLE is re-entered.
- Arithmetic:
  - Magnitude is unsigned WIDTH bits, so the most negative value -2^(WIDTH-1) maps to sign=1, mag=2^(WIDTH-1). No overflow.
  - Zero maps to sign=0, mag=0; there is no negative zero.
- Boundary conditions:
  - out_ready held high permanently: DONE lasts exactly one cycle.
  - out_ready=1 while not in DONE: ignored.
  - rst asserted mid-SHIFT or in DONE: the partial or pending result is discarded, out_valid=0 next cycle, and no output handshake occurs for that word.
  - in_valid and rst high on the same edge: reset wins and the word is not accepted.

Test Plan:
- Reset then in_data=8'h00 -> after 8 cycles out_valid=1, out_sign=0, out_mag=8'h00; with out_ready=1 back to IDLE, in_ready=1.
- Operand 8'h7F -> out_sign=0, out_mag=8'h7F. Operand 8'hFF -> out_sign=1, out_mag=8'h01.
- Operand 8'h80 -> out_sign=1, out_mag=8'h80. Operand 8'hB6 (-74) -> out_sign=1, out_mag=8'h4A. Check out_valid rises in the cycle after edge E0+8.
- Back-pressure: operand 8'hC0 with out_ready=0 for 5 cycles -> out_valid, out_sign=1, out_mag=8'h40 stable throughout, in_ready=0. Pulse in_valid with 8'h01 meanwhile -> ignored. Raise out_ready -> IDLE.
- Reset mid-operation: accept 8'h9C, assert rst on the 4th SHIFT cycle -> next cycle out_valid=0, busy=0, in_ready=1. New word 8'hF6 -> out_sign=1, out_mag=8'h0A with no residue from the aborted word.
- Exhaustive sweep of all 256 inputs, out_ready=1, in_valid held high -> each result matches a sign/abs reference model, and accepts are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's complement to sign-magnitude converter.
// A word is taken on the input valid/ready handshake. Its magnitude is built
// LSB-first with the "copy through the first 1, then invert" rule, and the
// result is offered on the output valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its data stable until that edge.
// in_ready is high only in IDLE. out_valid is high only in DONE, and out_sign
// and out_mag are stable while out_valid is high.
module twos_to_signmag_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;       // operand, consumed from bit 0
  logic [WIDTH-1:0] res_q, res_d;     // magnitude, filled from the MSB end
  logic [CW-1:0]    cnt_q, cnt_d;     // index of the bit being processed
  logic             sign_q, sign_d;
  logic             found_q, found_d; // a 1 has already been seen in this word
  logic             out_valid_q, out_valid_d;
  logic             res_bit;

  // Next-state and datapath: accept, shift one bit per cycle, then hold result.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    found_d     = found_q;
    out_valid_d = out_valid_q;
    res_bit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          sign_d  = in_data[WIDTH-1];
          found_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Bits below and including the lowest 1 pass unchanged; for negative
        // operands every bit above it is inverted.
        res_bit = (sign_q && found_q) ? ~op_q[0] : op_q[0];
        res_d   = {res_bit, res_q[WIDTH-1:1]};
        op_d    = {1'b0, op_q[WIDTH-1:1]};
        found_d = found_q | op_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; synchronous reset clears everything and returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      found_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      found_q     <= found_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_sign  = sign_q;
  assign out_mag   = res_q;

endmodule
